// File: rtl/truth_table_bist_pkg.sv
// Shared types and sizing for the 3-input truth-table BIST.
package truth_table_bist_pkg;
    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;
    localparam int ERR_W       = 4;
    localparam int TMR_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;
endpackage

// File: rtl/truth_table_bist_if.sv
// Control/status bundle between a BIST controller (master) and the BIST (slave).
interface truth_table_bist_if;
    import truth_table_bist_pkg::*;

    logic                   i_start;
    logic                   i_abort;
    logic [NUM_VECTORS-1:0] i_expected;
    logic                   i_f;
    logic                   o_a;
    logic                   o_b;
    logic                   o_c;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_pass;
    logic [ERR_W-1:0]       o_err_count;
    logic [NUM_VECTORS-1:0] o_err_map;

    modport master (
        output i_start, i_abort, i_expected, i_f,
        input  o_a, o_b, o_c, o_busy, o_done, o_pass, o_err_count, o_err_map
    );

    modport slave (
        input  i_start, i_abort, i_expected, i_f,
        output o_a, o_b, o_c, o_busy, o_done, o_pass, o_err_count, o_err_map
    );
endinterface

// File: rtl/truth_table_bist_settle_timer.sv
// Down-counter that times how long each stimulus vector is held before F is sampled.
module bist_settle_timer #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_en && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_expired = (r_cnt == '0);
endmodule

// File: rtl/truth_table_bist.sv
// Sweeps {A,B,C} through all 8 vectors, compares F against a latched golden table.
module truth_table_bist
    import truth_table_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    truth_table_bist_if.slave  bus
);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VECTORS - 1);

    state_t                 r_state, w_state_nxt;
    logic [IDX_W-1:0]       r_idx, w_idx_nxt;
    logic [IDX_W-1:0]       r_abc;
    logic [NUM_VECTORS-1:0] r_shadow;
    logic [NUM_VECTORS-1:0] r_err_map;
    logic [ERR_W-1:0]       r_err_count;
    logic                   w_tmr_load, w_tmr_expired;
    logic                   w_clear, w_latch, w_record, w_mismatch;
    logic                   w_busy_nxt;

    bist_settle_timer #(.W(TMR_W)) u_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_tmr_load),
        .i_load_val (SETTLE_LOAD),
        .i_en       (r_state == ST_SETTLE),
        .o_expired  (w_tmr_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_tmr_load  = 1'b0;
        w_clear     = 1'b0;
        w_latch     = 1'b0;
        w_record    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.i_start && !bus.i_abort) begin
                    w_state_nxt = ST_SETTLE;
                    w_idx_nxt   = '0;
                    w_tmr_load  = 1'b1;
                    w_clear     = 1'b1;
                    w_latch     = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (bus.i_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                    w_clear     = 1'b1;
                end else if (w_tmr_expired) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (bus.i_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                    w_clear     = 1'b1;
                end else begin
                    w_record = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_SETTLE;
                        w_idx_nxt   = r_idx + 1'b1;
                        w_tmr_load  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Case inequality so an X/Z on F counts as a failing vector.
    assign w_mismatch = (bus.i_f !== r_shadow[r_idx]);
    assign w_busy_nxt = (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_CHECK);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_idx       <= '0;
            r_abc       <= '0;
            r_shadow    <= '0;
            r_err_map   <= '0;
            r_err_count <= '0;
        end else begin
            r_idx <= w_idx_nxt;
            r_abc <= w_busy_nxt ? w_idx_nxt : '0;
            if (w_latch)
                r_shadow <= bus.i_expected;
            if (w_clear) begin
                r_err_map   <= '0;
                r_err_count <= '0;
            end else if (w_record && w_mismatch) begin
                r_err_map[r_idx] <= 1'b1;
                r_err_count      <= r_err_count + 1'b1;
            end
        end
    end

    assign bus.o_a         = r_abc[2];
    assign bus.o_b         = r_abc[1];
    assign bus.o_c         = r_abc[0];
    assign bus.o_busy      = (r_state == ST_SETTLE) || (r_state == ST_CHECK);
    assign bus.o_done      = (r_state == ST_DONE);
    assign bus.o_pass      = (r_state == ST_DONE) && (r_err_count == '0);
    assign bus.o_err_count = r_err_count;
    assign bus.o_err_map   = r_err_map;
endmodule

// File: doc/truth_table_bist.md
TRUTH_TABLE_BIST -- requirements
Module: truth_table_bist

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, cycles each vector is held before F is sampled (legal range 1..15).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin sweep; sampled only in IDLE or DONE.
REQ-005 abort  input  1  terminate sweep; sampled in SETTLE/CHECK.
REQ-006 expected  input  8  golden truth table, bit i = expected F for {A,B,C}=i.
REQ-007 F  input  1  output of the 3-input function unit under test.
REQ-008 A, B, C  output  1 each  registered stimulus to the unit, {A,B,C} = vector index.
REQ-009 busy  output  1  high in SETTLE/CHECK.
REQ-010 done  output  1  high in DONE.
REQ-011 pass  output  1  valid with done, 1 iff err_count==0.
REQ-012 err_count  output  4  number of mismatching vectors, 0..8.
REQ-013 err_map  output  8  bit i set iff vector i mismatched.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, CHECK, DONE.
REQ-015 IDLE/DONE with start=1: latch expected into a shadow register, idx<=0, err_count<=0, err_map<=0, done<=0, next state SETTLE.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles with {A,B,C}=idx, then go to CHECK.
REQ-017 CHECK (1 cycle): if F != shadow[idx], set err_map[idx] and increment err_count; if idx==7 go to DONE, else idx<=idx+1 and go to SETTLE.
REQ-018 Each vector SHALL take SETTLE_CYCLES+1 cycles; done SHALL rise 8*(SETTLE_CYCLES+1) cycles after the edge that sampled start (24 at default).
REQ-019 F SHALL be compared only in CHECK; any F value other than 0/1 SHALL be treated as a mismatch.
REQ-020 {A,B,C} SHALL be 3'b000 in IDLE and DONE.
REQ-021 DONE SHALL hold done, pass, err_count, err_map stable until start, reset or nothing else changes them.
REQ-022 start while busy SHALL be ignored; changes to expected while busy SHALL have no effect.
REQ-023 abort while busy: next state IDLE, busy=0, done=0, pass=0, err_count and err_map cleared.
REQ-024 abort and start in the same cycle while busy: abort wins; start in IDLE/DONE with abort=1 SHALL be ignored.
REQ-025 idx SHALL never wrap past 7; no ninth vector is driven.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE, A=B=C=0, busy=0, done=0, pass=0, err_count=0, err_map=0, idx=0, regardless of state.
REQ-027 reset SHALL take priority over start and abort; a sweep interrupted by reset SHALL not resume.

Structure
REQ-028 Package truth_table_bist_pkg SHALL hold the state enum, NUM_VECTORS=8, IDX_W=3, ERR_W=4.
REQ-029 One sub-module bist_settle_timer (load, count-down, expire flag) SHALL implement the SETTLE duration; all else in truth_table_bist.

Verification
REQ-030 expected=8'h5B, F from a correct model of F=A'BC+B'(AC'+A'C)+(ABC'+A'B')C' -> done at cycle 24, pass=1, err_count=0, err_map=8'h00.
REQ-031 expected=8'h5B, F stuck at 0 -> err_map=8'h5B, err_count=5, pass=0; stuck at 1 -> err_map=8'hA4, err_count=3.
REQ-032 start, then expected changed to 8'hFF at cycle 5 with correct F model -> pass=1, err_map=8'h00.
REQ-033 abort and start both high at cycle 10 -> IDLE next cycle, all status zero, no restart; later start runs a full clean sweep.
REQ-034 reset at cycle 12 mid-sweep -> all outputs zero next cycle, state IDLE; new start completes in 24 cycles.
REQ-035 start pulsed at cycle 7 (busy) ignored, done still at 24; start in DONE -> done=0 next cycle and a fresh sweep from vector 0.
